// File: rtl/periph_bus_arbiter.sv
// ---------------------------------------------------------------------------
// periph_bus_arbiter
//
// Shares the single peripheral bus between two masters (M0 = CPU data port,
// M1 = DMA engine) with round-robin arbitration and one transaction in flight.
// Fast devices complete in a single ACCESS cycle. Addresses inside the slow
// window [SLOW_LO, SLOW_HI] get a bus_stb/bus_sack handshake that is aborted
// with ERR_DATA and bus_err after TIMEOUT+1 unacknowledged WAIT cycles.
//
// Ports
//   clk                 system clock, all state on the rising edge
//   reset               synchronous, active-low reset
//   mX_req/we/addr/wd   master X request, held until mX_ack
//   mX_ack              1-cycle completion pulse to master X
//   mX_rd               master X read data, valid while mX_ack=1
//   bus_err             1-cycle pulse with the ack of a timed-out transaction
//   bus_we/addr/wd      write enable, address and write data to the bridge
//   bus_rd              read data from the bridge (combinational from bus_addr)
//   bus_stb             slow-window strobe
//   bus_sack            slow-device acknowledge, sampled only in WAIT
// ---------------------------------------------------------------------------
module periph_bus_arbiter #(
    parameter logic [31:0] SLOW_LO  = 32'h0000_7f10,
    parameter logic [31:0] SLOW_HI  = 32'h0000_7f2b,
    parameter logic [9:0]  TIMEOUT  = 10'd1023,
    parameter logic [31:0] ERR_DATA = 32'h1723_ffff
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    output logic        m0_ack,
    output logic [31:0] m0_rd,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    output logic        m1_ack,
    output logic [31:0] m1_rd,
    output logic        bus_err,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wd,
    input  logic [31:0] bus_rd,
    output logic        bus_stb,
    input  logic        bus_sack
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic in_slow_window(input logic [31:0] addr);
        return (addr >= SLOW_LO) && (addr <= SLOW_HI);
    endfunction

    state_t      state_q,    state_d;
    logic        last_gnt_q, last_gnt_d;   // 0 = M0, 1 = M1; only ties update it
    logic        gnt_q,      gnt_d;        // master owning the in-flight transaction
    logic [9:0]  cnt_q,      cnt_d;
    logic        m0_ack_q,   m0_ack_d;
    logic        m1_ack_q,   m1_ack_d;
    logic [31:0] m0_rd_q,    m0_rd_d;
    logic [31:0] m1_rd_q,    m1_rd_d;
    logic        bus_err_q,  bus_err_d;
    logic        bus_we_q,   bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wd_q,   bus_wd_d;
    logic        bus_stb_q,  bus_stb_d;

    logic        win_s;        // arbitration winner in IDLE
    logic [31:0] win_addr_s;
    logic        cap_s;        // transaction completes at this edge
    logic [31:0] cap_data_s;
    logic        cap_err_s;

    // Next-state, arbitration and completion logic
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_rd_d    = m0_rd_q;
        m1_rd_d    = m1_rd_q;
        bus_err_d  = 1'b0;
        bus_we_d   = bus_we_q;
        bus_addr_d = bus_addr_q;
        bus_wd_d   = bus_wd_q;
        bus_stb_d  = bus_stb_q;
        win_s      = 1'b0;
        win_addr_s = m0_addr;
        cap_s      = 1'b0;
        cap_data_s = bus_rd;
        cap_err_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bus_we_d  = 1'b0;
                bus_stb_d = 1'b0;
                if (m0_req || m1_req) begin
                    if (m0_req && m1_req) begin
                        win_s      = ~last_gnt_q;
                        last_gnt_d = ~last_gnt_q;
                    end else begin
                        win_s = m1_req;
                    end
                    win_addr_s = win_s ? m1_addr : m0_addr;
                    gnt_d      = win_s;
                    bus_addr_d = win_addr_s;
                    bus_wd_d   = win_s ? m1_wd : m0_wd;
                    // Registered outputs: the ACCESS-cycle values are loaded here
                    bus_we_d   = win_s ? m1_we : m0_we;
                    bus_stb_d  = in_slow_window(win_addr_s);
                    state_d    = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (bus_stb_q) begin
                    cnt_d   = 10'd0;
                    state_d = ST_WAIT;
                end else begin
                    bus_we_d   = 1'b0;
                    cap_s      = 1'b1;
                    cap_data_s = bus_rd;
                    state_d    = ST_DONE;
                end
            end
            ST_WAIT: begin
                // An acknowledge in the timeout cycle still counts as success
                if (bus_sack) begin
                    cap_s      = 1'b1;
                    cap_data_s = bus_rd;
                    bus_we_d   = 1'b0;
                    bus_stb_d  = 1'b0;
                    state_d    = ST_DONE;
                end else if (cnt_q == TIMEOUT) begin
                    cap_s      = 1'b1;
                    cap_data_s = ERR_DATA;
                    cap_err_s  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_stb_d  = 1'b0;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            ST_DONE: begin
                bus_we_d  = 1'b0;
                bus_stb_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                bus_we_d  = 1'b0;
                bus_stb_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        // Completion loads the owner's ack/rd so they are visible in DONE
        if (cap_s) begin
            bus_err_d = cap_err_s;
            if (gnt_q) begin
                m1_ack_d = 1'b1;
                m1_rd_d  = cap_data_s;
            end else begin
                m0_ack_d = 1'b1;
                m0_rd_d  = cap_data_s;
            end
        end else begin
            bus_err_d = 1'b0;
        end
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= 1'b1;
            gnt_q      <= 1'b0;
            cnt_q      <= 10'd0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rd_q    <= 32'd0;
            m1_rd_q    <= 32'd0;
            bus_err_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= 32'd0;
            bus_wd_q   <= 32'd0;
            bus_stb_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_rd_q    <= m0_rd_d;
            m1_rd_q    <= m1_rd_d;
            bus_err_q  <= bus_err_d;
            bus_we_q   <= bus_we_d;
            bus_addr_q <= bus_addr_d;
            bus_wd_q   <= bus_wd_d;
            bus_stb_q  <= bus_stb_d;
        end
    end

    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_rd    = m0_rd_q;
    assign m1_rd    = m1_rd_q;
    assign bus_err  = bus_err_q;
    assign bus_we   = bus_we_q;
    assign bus_addr = bus_addr_q;
    assign bus_wd   = bus_wd_q;
    assign bus_stb  = bus_stb_q;

endmodule
